// File: rtl/simpsons_sensor.sv
// Two-beam doorway passage classifier: Bart (low beam only) or Homer (high beam first) toggles a presence flag.
// Optional macro SIMPSONS_SENSOR_SYNC_EN adds a 2-flop synchronizer on G for asynchronous sensors.
module simpsons_sensor #(
    parameter logic [1:0] INIT_LEVEL = 2'b00
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] G,
    output logic [1:0] LEVEL
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BART       = 3'd1,
        S_HOMER_HEAD = 3'd2,
        S_HOMER_BODY = 3'd3,
        S_ABORT      = 3'd4
    } state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_LOW  = 2'b01;
    localparam logic [1:0] G_HIGH = 2'b10;
    localparam logic [1:0] G_BOTH = 2'b11;

    state_t     r_state;
    logic [1:0] r_level;
    logic [1:0] w_g;

`ifdef SIMPSONS_SENSOR_SYNC_EN
    logic [1:0] r_sync_meta;
    logic [1:0] r_sync_out;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync_meta <= 2'b00;
            r_sync_out  <= 2'b00;
        end else begin
            r_sync_meta <= G;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_g = r_sync_out;
`else
    assign w_g = G;
`endif

    // A passage only counts when the terminating 00 arrives; anything unexpected parks in ABORT until then.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_level <= INIT_LEVEL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    case (w_g)
                        G_LOW:   r_state <= S_BART;
                        G_HIGH:  r_state <= S_HOMER_HEAD;
                        G_BOTH:  r_state <= S_ABORT;
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_BART: begin
                    case (w_g)
                        G_NONE: begin
                            r_level[0] <= ~r_level[0];
                            r_state    <= S_IDLE;
                        end
                        G_LOW:   r_state <= S_BART;
                        default: r_state <= S_ABORT;
                    endcase
                end
                S_HOMER_HEAD: begin
                    case (w_g)
                        G_NONE:  r_state <= S_IDLE;
                        G_HIGH:  r_state <= S_HOMER_HEAD;
                        default: r_state <= S_HOMER_BODY;
                    endcase
                end
                S_HOMER_BODY: begin
                    if (w_g == G_NONE) begin
                        r_level[1] <= ~r_level[1];
                        r_state    <= S_IDLE;
                    end else begin
                        r_state <= S_HOMER_BODY;
                    end
                end
                S_ABORT: begin
                    if (w_g == G_NONE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_ABORT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign LEVEL = r_level;

endmodule

// File: tb/tb_simpsons_sensor.sv
// Scoreboard bench for simpsons_sensor: randomized and directed passages checked against a
// sequence-classifying reference model; a monitor compares LEVEL every cycle.
module tb_simpsons_sensor;

    localparam logic [1:0] INIT = 2'b00;
`ifdef SIMPSONS_SENSOR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk   = 1'b0;
    logic       rstN  = 1'b0;
    logic [1:0] g     = 2'b00;
    logic [1:0] level;

    int checks = 0;
    int errors = 0;
    bit monEn  = 1'b0;

    logic [1:0] expQ[$];
    logic [1:0] seen[$];
    logic [1:0] modelLevel = INIT;

    simpsons_sensor #(.INIT_LEVEL(INIT)) dut (
        .CLK  (clk),
        .RESET(rstN),
        .G    (g),
        .LEVEL(level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [1:0] expVal);
        checks++;
        if (level !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: LEVEL=%b expected=%b at %0t", name, level, expVal, $time);
        end
    endtask

    // Reference model: collect the non-zero samples of a passage and judge the whole sequence at the separator.
    function automatic void stepModel(input logic [1:0] gs);
        bit ok;
        if (gs != 2'b00) begin
            seen.push_back(gs);
        end else begin
            if (seen.size() > 0) begin
                if (seen[0] == 2'b01) begin
                    ok = 1'b1;
                    foreach (seen[i]) if (seen[i] != 2'b01) ok = 1'b0;
                    if (ok) modelLevel[0] = ~modelLevel[0];
                end else if (seen[0] == 2'b10) begin
                    ok = 1'b0;
                    foreach (seen[i]) if (seen[i] != 2'b10) ok = 1'b1;
                    if (ok) modelLevel[1] = ~modelLevel[1];
                end
            end
            seen.delete();
        end
        expQ.push_back(modelLevel);
    endfunction

    task automatic applyStimulus(input logic [1:0] gv);
        @(negedge clk);
        g = gv;
        stepModel(gv);
    endtask

    task automatic holdPattern(input logic [1:0] gv, input int n);
        repeat (n) applyStimulus(gv);
    endtask

    // kind: 0 Bart, 1 Homer 10/01, 2 Homer 10/11, 3 head withdrawn, 4 both-beams abort, 5 Bart then high, 6 long Homer
    task automatic passage(input int kind, input int hold);
        logic [1:0] pat[$];
        case (kind)
            0: pat = '{2'b01};
            1: pat = '{2'b10, 2'b01};
            2: pat = '{2'b10, 2'b11};
            3: pat = '{2'b10};
            4: pat = '{2'b11};
            5: pat = '{2'b01, 2'b10};
            default: pat = '{2'b10, 2'b11, 2'b01, 2'b10};
        endcase
        foreach (pat[i]) holdPattern(pat[i], (hold > 0) ? hold : int'($urandom_range(1, 2)));
        holdPattern(2'b00, (hold > 0) ? hold : int'($urandom_range(1, 2)));
    endtask

    task automatic settleAndCheck(input string name, input logic [1:0] expVal);
        holdPattern(2'b00, LAT);
        #1;
        checkOutput(name, expVal);
    endtask

    task automatic restartModel(input bit stepNow);
        expQ.delete();
        seen.delete();
        modelLevel = INIT;
        repeat (LAT - 1) expQ.push_back(INIT);
        if (stepNow) stepModel(g);
        monEn = 1'b1;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #2;
        monEn = 1'b0;
        rstN  = 1'b0;
        #1;
        checkOutput("reset_pulse", INIT);
        rstN = 1'b1;
        restartModel(1'b1);
        #1;
        checkOutput("reset_release", INIT);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (monEn && expQ.size() > 0) checkOutput("scoreboard", expQ.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got time %0t required < 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_init", INIT);
        @(negedge clk);
        #2;
        rstN = 1'b1;
        restartModel(1'b1);

        passage(0, 2);  settleAndCheck("bart_in", 2'b01);
        passage(0, 2);  settleAndCheck("bart_out", 2'b00);
        passage(1, 1);  settleAndCheck("homer_low", 2'b10);
        passage(2, 1);  settleAndCheck("homer_both", 2'b00);

        passage(0, 0);  settleAndCheck("mix_b", 2'b01);
        passage(1, 0);  settleAndCheck("mix_bh", 2'b11);
        passage(2, 0);  settleAndCheck("mix_h1", 2'b01);
        passage(1, 0);  settleAndCheck("mix_h2", 2'b11);
        passage(0, 0);  settleAndCheck("mix_b1", 2'b10);
        passage(0, 0);  settleAndCheck("mix_b2", 2'b11);
        passage(6, 0);  settleAndCheck("mix_h3", 2'b01);
        passage(0, 0);  settleAndCheck("mix_b3", 2'b00);

        passage(1, 0);  settleAndCheck("pre_reset", 2'b10);
        resetPulse();
        passage(1, 0);  settleAndCheck("post_reset_homer", 2'b10);
        passage(1, 0);  settleAndCheck("homer_clear", 2'b00);

        passage(3, 0);  settleAndCheck("abort_head", 2'b00);
        passage(4, 0);  settleAndCheck("abort_both", 2'b00);
        passage(5, 0);  settleAndCheck("abort_bart_high", 2'b00);

        // Reset held across an edge mid-passage, released while G=01; G drops to 00 before any edge sees 01.
        applyStimulus(2'b10);
        holdPattern(2'b01, 2);
        @(negedge clk);
        #2;
        monEn = 1'b0;
        rstN  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_hold", INIT);
        rstN = 1'b1;
        #2;
        g = 2'b00;
        restartModel(1'b0);
        holdPattern(2'b00, 2);
        settleAndCheck("reset_mid_discard", INIT);

        for (int n = 0; n < 40; n++) passage(int'($urandom_range(0, 6)), 0);
        for (int n = 0; n < 20; n++) begin
            int len;
            len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++)
                holdPattern(2'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            holdPattern(2'b00, int'($urandom_range(1, 2)));
        end
        settleAndCheck("random_final", modelLevel);

        repeat (LAT + 2) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: queue depth=%0d expected=0", expQ.size());
        end
        monEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
